// File: rtl/dvi_pkg.sv
// dvi_pkg: shared DVI pipeline widths, active-area defaults and pattern mode codes
package dvi_pkg;
  localparam int X_POS_W = 10;
  localparam int Y_POS_W = 10;
  localparam int COLOR_W = 8;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  typedef enum logic [2:0] {SOLID, COLOR_BARS, CHECKER, GRADIENT, BOUNCE_BOX} pattern_mode_t;
  function automatic pattern_mode_t next_mode(input pattern_mode_t m);
    return m == BOUNCE_BOX ? SOLID : pattern_mode_t'(m + 3'd1);
  endfunction
  function automatic pattern_mode_t to_mode(input logic [2:0] c);
    return c > 3'd4 ? SOLID : pattern_mode_t'(c);
  endfunction
endpackage

// File: rtl/bounce_pos.sv
// bounce_pos: one-axis position stepping each tick, clamping and reversing on touching 0 or LIMIT
module bounce_pos #(
  parameter int W = 10,
  parameter int LIMIT = 576,
  parameter int STEP = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  output logic [W-1:0] pos
);
  logic dir;
  logic [W:0] up, dn;
  logic up_hit, dn_hit;
  always_comb begin
    up = {1'b0, pos} + (W+1)'(STEP);
    dn = {1'b0, pos} - (W+1)'(STEP);
    up_hit = up >= (W+1)'(LIMIT);
    dn_hit = dn[W] || dn == '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      pos <= '0;
      dir <= 1'b0;
    end else if (tick) begin
      pos <= dir ? (dn_hit ? '0 : dn[W-1:0]) : (up_hit ? W'(LIMIT) : up[W-1:0]);
      dir <= dir ? !dn_hit : up_hit;
    end
endmodule

// File: rtl/pattern_gen.sv
// pattern_gen: registered five-mode test-pattern generator; PATTERN_GEN_CROSSHAIR_EN adds a centre crosshair
module pattern_gen
  import dvi_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int CHECK_LOG2 = 5,
  parameter int BOX_SIZE = 64,
  parameter int BOX_STEP = 4,
  parameter int AUTO_FRAMES = 120,
  parameter int INIT_MODE = 1,
  parameter logic [3*COLOR_W-1:0] SOLID_RGB = 24'h0000FF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [X_POS_W-1:0] x_i,
  input  logic [Y_POS_W-1:0] y_i,
  input  logic [2:0]         mode_i,
  input  logic               mode_valid_i,
  output logic               mode_ready_o,
  input  logic               auto_i,
  output logic [2:0]         mode_o,
  output logic               frame_tick_o,
  output logic [COLOR_W-1:0] red_o,
  output logic [COLOR_W-1:0] green_o,
  output logic [COLOR_W-1:0] blue_o
);
  localparam int CNT_W = $clog2(AUTO_FRAMES + 1);
  localparam logic [COLOR_W-1:0] ON = '1;
  localparam logic [COLOR_W-1:0] OFF = '0;
  localparam logic [COLOR_W-1:0] GREY = {1'b1, {(COLOR_W-1){1'b0}}};
  pattern_mode_t mode_q, pend_mode;
  logic pend_q, prev_zero, at_zero, tick, active, in_box, wrap;
  logic [CNT_W-1:0] cnt_q;
  logic [X_POS_W-1:0] box_x;
  logic [Y_POS_W-1:0] box_y;
  logic [2:0] bar;
  logic [3*COLOR_W-1:0] rgb, rgb_q;
  bounce_pos #(.W(X_POS_W), .LIMIT(H_ACTIVE - BOX_SIZE), .STEP(BOX_STEP)) u_box_x (
    .clk(clk_i), .rst(rst_i), .tick(tick), .pos(box_x)
  );
  bounce_pos #(.W(Y_POS_W), .LIMIT(V_ACTIVE - BOX_SIZE), .STEP(BOX_STEP)) u_box_y (
    .clk(clk_i), .rst(rst_i), .tick(tick), .pos(box_y)
  );
  always_comb begin
    at_zero = x_i == '0 && y_i == '0;
    tick = at_zero && !prev_zero;
    wrap = cnt_q == CNT_W'(AUTO_FRAMES - 1);
    active = x_i < X_POS_W'(H_ACTIVE) && y_i < Y_POS_W'(V_ACTIVE);
    bar = 3'(x_i / X_POS_W'(H_ACTIVE / 8));
    in_box = x_i >= box_x && y_i >= box_y
      && {1'b0, x_i} < {1'b0, box_x} + (X_POS_W+1)'(BOX_SIZE)
      && {1'b0, y_i} < {1'b0, box_y} + (Y_POS_W+1)'(BOX_SIZE);
    case (mode_q)
      COLOR_BARS: rgb = {{COLOR_W{~bar[1]}}, {COLOR_W{~bar[2]}}, {COLOR_W{~bar[0]}}};
      CHECKER:    rgb = {3{x_i[CHECK_LOG2] ^ y_i[CHECK_LOG2] ? ON : OFF}};
      GRADIENT:   rgb = {COLOR_W'(x_i), COLOR_W'(y_i), COLOR_W'(x_i) ^ COLOR_W'(y_i)};
      BOUNCE_BOX: rgb = {3{in_box ? ON : GREY}};
      default:    rgb = SOLID_RGB;
    endcase
`ifdef PATTERN_GEN_CROSSHAIR_EN
    if (x_i == X_POS_W'(H_ACTIVE / 2) || y_i == Y_POS_W'(V_ACTIVE / 2)) rgb = '1;
`endif
  end
  always_ff @(posedge clk_i)
    prev_zero <= at_zero;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      mode_q <= to_mode(3'(INIT_MODE));
      pend_mode <= SOLID;
      pend_q <= 1'b0;
      cnt_q <= '0;
      frame_tick_o <= 1'b0;
      rgb_q <= '0;
    end else begin
      frame_tick_o <= tick;
      rgb_q <= active ? rgb : '0;
      if (tick && pend_q) begin
        mode_q <= pend_mode;
        cnt_q <= '0;
        pend_q <= 1'b0;
      end else begin
        if (tick && auto_i) begin
          cnt_q <= wrap ? '0 : cnt_q + CNT_W'(1);
          if (wrap) mode_q <= next_mode(mode_q);
        end
        if (mode_valid_i && !pend_q) begin
          pend_q <= 1'b1;
          pend_mode <= to_mode(mode_i);
        end
      end
    end
  assign mode_ready_o = !pend_q;
  assign mode_o = mode_q;
  assign {red_o, green_o, blue_o} = rgb_q;
endmodule
